deadline_trap_ctrl: RTL and testbench

Responder side of the instruction-deadline timer. It arms the timer, consumes the timer's timeout, and turns it into a precise trap. On a trap it saves the interrupted PC, stops the timer, redirects fetch to the handler, and on eret returns to the saved PC, optionally re-arming the timer. It also arbitrates one external interrupt line against the deadline timeout.

---
 rtl/deadline_trap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_deadline_trap_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/deadline_trap_ctrl.sv
// Purpose : responder side of the instruction-deadline timer. Arms the timer, turns its
//           timeout (or a pending external interrupt) into a precise trap, saves the
//           interrupted PC, redirects fetch to the handler and back on eret.
// Latency : arm -> start_time 1 cycle; timeout/ext_pend -> redirect+dl_stop 1 cycle;
//           eret -> return redirect 1 cycle. All outputs are registered.
// Backpressure: none; pulses are single-cycle. Events arriving in the handler are
//           ignored, except ext_irq, which is remembered in a sticky pending flag.
//
// Ports:
//   cpu_clk, reset        clock and synchronous active-high reset
//   arm                   start/restart the deadline window (pulse)
//   timeout               deadline timer reached its threshold (level)
//   ext_irq, irq_en       external interrupt request and its enable
//   pc                    PC of the oldest not-yet-retired instruction
//   eret, eret_rearm      return from handler, optionally restarting the deadline
//   start_time, dl_stop   timer start / stop pulses
//   redirect, redirect_pc pipeline flush and new fetch address
//   epc, cause            saved return PC and trap cause (0 none, 1 deadline, 2 external)
//   in_handler            high while the handler runs

module deadline_trap_ctrl #(
    parameter int unsigned          PC_W         = 32,
    parameter logic [PC_W-1:0]      HANDLER_ADDR = 32'h0000_0080
) (
    input  logic            cpu_clk,
    input  logic            reset,
    input  logic            arm,
    input  logic            timeout,
    input  logic            ext_irq,
    input  logic            irq_en,
    input  logic [PC_W-1:0] pc,
    input  logic            eret,
    input  logic            eret_rearm,
    output logic            start_time,
    output logic            dl_stop,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic [1:0]      cause,
    output logic            in_handler
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        ARMED   = 3'd2,
        TRAP    = 3'd3,
        HANDLER = 3'd4,
        RETURN  = 3'd5
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_DEADLINE = 2'd1;
    localparam logic [1:0] CAUSE_EXT      = 2'd2;

    state_t          state_q, state_d;
    logic [1:0]      trap_cause_d;
    logic            take_ext_d;

    logic            ext_pend_q;
    logic            rearm_q;
    logic            start_time_q;
    logic            dl_stop_q;
    logic            redirect_q;
    logic [PC_W-1:0] redirect_pc_q;
    logic [PC_W-1:0] epc_q;
    logic [1:0]      cause_q;
    logic            in_handler_q;

    // Next-state decision. trap_cause_d is only meaningful when state_d is TRAP;
    // take_ext_d marks that the pending external request is consumed by this trap.
    always_comb begin
        state_d      = state_q;
        trap_cause_d = CAUSE_NONE;
        take_ext_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ext_pend_q) begin
                    state_d      = TRAP;
                    trap_cause_d = CAUSE_EXT;
                    take_ext_d   = 1'b1;
                end else if (arm) begin
                    state_d = START;
                end
            end
            START: state_d = ARMED;
            ARMED: begin
                // A fresh arm restarts the window and masks a coincident timeout;
                // the deadline outranks the external request, which stays pending.
                if (arm) begin
                    state_d = START;
                end else if (timeout) begin
                    state_d      = TRAP;
                    trap_cause_d = CAUSE_DEADLINE;
                end else if (ext_pend_q) begin
                    state_d      = TRAP;
                    trap_cause_d = CAUSE_EXT;
                    take_ext_d   = 1'b1;
                end
            end
            TRAP: state_d = HANDLER;
            HANDLER: begin
                if (eret) begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                if (rearm_q) begin
                    state_d = START;
                end else if (ext_pend_q) begin
                    state_d      = TRAP;
                    trap_cause_d = CAUSE_EXT;
                    take_ext_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state
    // they describe, without any input-to-output combinational path.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ext_pend_q    <= 1'b0;
            rearm_q       <= 1'b0;
            start_time_q  <= 1'b0;
            dl_stop_q     <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            epc_q         <= '0;
            cause_q       <= CAUSE_NONE;
            in_handler_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            // A new request in the same cycle as the trap that consumes the old
            // one is kept, so it is not lost.
            ext_pend_q <= (ext_pend_q && !take_ext_d) || (ext_irq && irq_en);

            if (state_q == HANDLER && eret) begin
                rearm_q <= eret_rearm;
            end

            start_time_q <= (state_d == START);
            dl_stop_q    <= (state_d == TRAP);
            redirect_q   <= (state_d == TRAP) || (state_d == RETURN);
            in_handler_q <= (state_d == HANDLER);

            case (state_d)
                TRAP:    redirect_pc_q <= HANDLER_ADDR;
                RETURN:  redirect_pc_q <= epc_q;
                default: redirect_pc_q <= '0;
            endcase

            if (state_d == TRAP) begin
                epc_q   <= pc;
                cause_q <= trap_cause_d;
            end else if (state_d == RETURN) begin
                cause_q <= CAUSE_NONE;
            end
        end
    end

    assign start_time  = start_time_q;
    assign dl_stop     = dl_stop_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign epc         = epc_q;
    assign cause       = cause_q;
    assign in_handler  = in_handler_q;

endmodule

// File: tb/tb_deadline_trap_ctrl.sv
module tb_deadline_trap_ctrl;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        timeout;
    logic        ext_irq;
    logic        irq_en;
    logic [31:0] pc;
    logic        eret;
    logic        eret_rearm;
    logic        start_time;
    logic        dl_stop;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic        in_handler;

    int total = 0;
    int bad   = 0;

    deadline_trap_ctrl #(
        .PC_W        (32),
        .HANDLER_ADDR(32'h0000_0080)
    ) dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .arm        (arm),
        .timeout    (timeout),
        .ext_irq    (ext_irq),
        .irq_en     (irq_en),
        .pc         (pc),
        .eret       (eret),
        .eret_rearm (eret_rearm),
        .start_time (start_time),
        .dl_stop    (dl_stop),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .epc        (epc),
        .cause      (cause),
        .in_handler (in_handler)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks every output against hand-computed values.
    task automatic chk_out(input string tag,
                           input logic st, input logic ds, input logic rd,
                           input logic [31:0] rpc, input logic [1:0] cs,
                           input logic ih, input logic [31:0] ep);
        chk({tag, ".start_time"},  {31'd0, start_time}, {31'd0, st});
        chk({tag, ".dl_stop"},     {31'd0, dl_stop},    {31'd0, ds});
        chk({tag, ".redirect"},    {31'd0, redirect},   {31'd0, rd});
        chk({tag, ".redirect_pc"}, redirect_pc,         rpc);
        chk({tag, ".cause"},       {30'd0, cause},      {30'd0, cs});
        chk({tag, ".in_handler"},  {31'd0, in_handler}, {31'd0, ih});
        chk({tag, ".epc"},         epc,                 ep);
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; timeout = 1'b0; ext_irq = 1'b0; irq_en = 1'b0;
        pc = 32'h0; eret = 1'b0; eret_rearm = 1'b0;
        tick(); tick();
        chk_out("reset", 0, 0, 0, 32'h0, 0, 0, 32'h0);

        // 1: arm -> one start_time pulse, then ARMED quietly
        reset = 1'b0;
        tick();
        arm = 1'b1;
        tick(); arm = 1'b0;
        chk_out("t1_start", 1, 0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        chk_out("t1_armed", 0, 0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        chk_out("t1_armed2", 0, 0, 0, 32'h0, 0, 0, 32'h0);

        // 2: deadline trap
        pc = 32'h40; timeout = 1'b1;
        tick(); timeout = 1'b0; pc = 32'h44;
        chk_out("t2_trap", 0, 1, 1, 32'h80, 1, 0, 32'h40);
        tick();
        chk_out("t2_handler", 0, 0, 0, 32'h0, 1, 1, 32'h40);
        timeout = 1'b1; arm = 1'b1;      // ignored inside the handler
        tick(); timeout = 1'b0; arm = 1'b0;
        chk_out("t2_handler_ign", 0, 0, 0, 32'h0, 1, 1, 32'h40);

        // 3: eret with rearm, then eret without rearm
        eret = 1'b1; eret_rearm = 1'b1;
        tick(); eret = 1'b0; eret_rearm = 1'b0;
        chk_out("t3_return", 0, 0, 1, 32'h40, 0, 0, 32'h40);
        tick();
        chk_out("t3_restart", 1, 0, 0, 32'h0, 0, 0, 32'h40);
        tick();
        chk_out("t3_armed", 0, 0, 0, 32'h0, 0, 0, 32'h40);
        pc = 32'h100; timeout = 1'b1;
        tick(); timeout = 1'b0;
        chk_out("t3_trap2", 0, 1, 1, 32'h80, 1, 0, 32'h100);
        tick();
        chk_out("t3_handler2", 0, 0, 0, 32'h0, 1, 1, 32'h100);
        eret = 1'b1; eret_rearm = 1'b0;
        tick(); eret = 1'b0;
        chk_out("t3_return2", 0, 0, 1, 32'h100, 0, 0, 32'h100);
        tick();
        chk_out("t3_idle", 0, 0, 0, 32'h0, 0, 0, 32'h100);
        timeout = 1'b1;                  // ignored in IDLE
        tick(); timeout = 1'b0;
        chk_out("t3_idle_to", 0, 0, 0, 32'h0, 0, 0, 32'h100);

        // 4: simultaneous timeout and external irq; deadline wins, ext follows return
        arm = 1'b1;
        tick(); arm = 1'b0;
        chk_out("t4_start", 1, 0, 0, 32'h0, 0, 0, 32'h100);
        tick();
        pc = 32'h200; timeout = 1'b1; ext_irq = 1'b1; irq_en = 1'b1;
        tick(); timeout = 1'b0; ext_irq = 1'b0;
        chk_out("t4_trap_dl", 0, 1, 1, 32'h80, 1, 0, 32'h200);
        tick();
        chk_out("t4_handler", 0, 0, 0, 32'h0, 1, 1, 32'h200);
        pc = 32'h300; eret = 1'b1; eret_rearm = 1'b0;
        tick(); eret = 1'b0;
        chk_out("t4_return", 0, 0, 1, 32'h200, 0, 0, 32'h200);
        tick();
        chk_out("t4_trap_ext", 0, 1, 1, 32'h80, 2, 0, 32'h300);
        tick();
        chk_out("t4_handler_ext", 0, 0, 0, 32'h0, 2, 1, 32'h300);
        eret = 1'b1;
        tick(); eret = 1'b0;
        chk_out("t4_return_ext", 0, 0, 1, 32'h300, 0, 0, 32'h300);
        tick();
        chk_out("t4_idle", 0, 0, 0, 32'h0, 0, 0, 32'h300);
        tick();
        chk_out("t4_idle2", 0, 0, 0, 32'h0, 0, 0, 32'h300);

        // 5: arm beats timeout; masked ext_irq never pends; enabled one traps
        arm = 1'b1;
        tick(); arm = 1'b0;
        tick();
        chk_out("t5_armed", 0, 0, 0, 32'h0, 0, 0, 32'h300);
        arm = 1'b1; timeout = 1'b1;
        tick(); arm = 1'b0; timeout = 1'b0;
        chk_out("t5_rearm", 1, 0, 0, 32'h0, 0, 0, 32'h300);
        tick();
        irq_en = 1'b0; ext_irq = 1'b1;
        tick();
        chk_out("t5_masked", 0, 0, 0, 32'h0, 0, 0, 32'h300);
        tick(); ext_irq = 1'b0;
        chk_out("t5_masked2", 0, 0, 0, 32'h0, 0, 0, 32'h300);
        tick();
        chk_out("t5_masked3", 0, 0, 0, 32'h0, 0, 0, 32'h300);
        pc = 32'h400; irq_en = 1'b1; ext_irq = 1'b1;
        tick(); ext_irq = 1'b0;
        chk_out("t5_pend", 0, 0, 0, 32'h0, 0, 0, 32'h300);
        tick();
        chk_out("t5_trap_ext", 0, 1, 1, 32'h80, 2, 0, 32'h400);
        tick();
        chk_out("t5_handler", 0, 0, 0, 32'h0, 2, 1, 32'h400);

        // 6: reset in HANDLER and in TRAP aborts silently
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk_out("t6_rst_handler", 0, 0, 0, 32'h0, 0, 0, 32'h0);
        arm = 1'b1;
        tick(); arm = 1'b0;
        tick();
        pc = 32'h600; timeout = 1'b1;
        tick(); timeout = 1'b0;
        chk_out("t6_trap", 0, 1, 1, 32'h80, 1, 0, 32'h600);
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk_out("t6_rst_trap", 0, 0, 0, 32'h0, 0, 0, 32'h0);
        eret = 1'b1; eret_rearm = 1'b1;
        tick(); eret = 1'b0; eret_rearm = 1'b0;
        chk_out("t6_eret_idle", 0, 0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        chk_out("t6_eret_idle2", 0, 0, 0, 32'h0, 0, 0, 32'h0);

        // pending external request taken straight from IDLE
        ext_irq = 1'b1; irq_en = 1'b1; pc = 32'h500;
        tick(); ext_irq = 1'b0;
        chk_out("t7_pend_idle", 0, 0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        chk_out("t7_trap_idle", 0, 1, 1, 32'h80, 2, 0, 32'h500);
        tick();
        chk_out("t7_handler", 0, 0, 0, 32'h0, 2, 1, 32'h500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
